// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// Holds the funct3 operation encoding, the controller state encoding and
// small helpers that classify an operation by the signedness of its
// operands and by whether it uses the divider.
package mdu_pkg;

  // Operation codes match the funct3 field of the M-extension instructions
  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINISH
  } mdu_state_e;

  // rs1 is treated as two's complement for MULH, MULHSU, DIV and REM
  function automatic logic is_signed_rs1(mdu_op_e op);
    return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  // rs2 is treated as two's complement for MULH, DIV and REM
  function automatic logic is_signed_rs2(mdu_op_e op);
    return op inside {MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

  // The upper half of the encoding selects the divider
  function automatic logic is_div_op(mdu_op_e op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Request/response bundle between the execute stage and the multiply/divide
// unit.
//   start     request, taken only while busy is low
//   op        funct3 operation code
//   operand1  rs1 (multiplicand / dividend)
//   operand2  rs2 (multiplier / divisor)
//   flush     kill the operation in flight
//   busy      operation in progress
//   done      one-cycle pulse, result valid
//   result    registered result, held between operations
//   zero      result == 0, registered with result
interface mdu_if #(
  parameter int XLEN = 32
);

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            zero;

  // The pipeline side issues requests
  modport master (
    output start, op, operand1, operand2, flush,
    input  busy, done, result, zero
  );

  // The unit side services them
  modport slave (
    input  start, op, operand1, operand2, flush,
    output busy, done, result, zero
  );

endinterface

// File: rtl/mdu_sign_fix.sv
// Final sign correction and result selection for the multiply/divide unit.
// The iterative datapath works on magnitudes only; this block restores the
// signs and picks the word the operation asks for.
//   op      operation code
//   acc     accumulator: full product, or {remainder, quotient}
//   sign1   rs1 was negative and treated as signed
//   sign2   rs2 was negative and treated as signed
//   result  corrected, selected result word
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mdu_op_e           op,
  input  logic [2*XLEN-1:0] acc,
  input  logic              sign1,
  input  logic              sign2,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;

  // Product and quotient are negative when exactly one operand was; the
  // remainder always follows the dividend so that q*d + r == dividend
  always_comb begin
    product   = (sign1 ^ sign2) ? -acc : acc;
    quotient  = (sign1 ^ sign2) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    remainder = sign1 ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    result    = '0;
    unique case (op)
      MDU_MUL:                          result = product[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU:  result = product[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:                result = quotient;
      MDU_REM, MDU_REMU:                result = remainder;
      default:                          result = '0;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, on
// operand magnitudes; signs are restored when the result is registered.
// Divide-by-zero and signed overflow bypass the iteration entirely.
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    slave side of mdu_if (start/op/operands/flush in,
//          busy/done/result/zero out)
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q, op_d;
  logic              sign1_q, sign1_d;
  logic              sign2_q, sign2_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q;
  logic              zero_q;
  logic              load_result;
  logic [XLEN-1:0]   fixed_result;

  mdu_op_e           in_op;
  logic              in_sign1;
  logic              in_sign2;
  logic [XLEN-1:0]   in_mag1;
  logic [XLEN-1:0]   in_mag2;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] div_next;

  assign in_op = mdu_op_e'(bus.op);

  // Magnitudes and sign flags of the incoming request; unsigned operands
  // pass through untouched and never report a sign
  always_comb begin
    in_sign1 = is_signed_rs1(in_op) & bus.operand1[XLEN-1];
    in_sign2 = is_signed_rs2(in_op) & bus.operand2[XLEN-1];
    in_mag1  = in_sign1 ? -bus.operand1 : bus.operand1;
    in_mag2  = in_sign2 ? -bus.operand2 : bus.operand2;
  end

  // One iteration of each algorithm.
  // Multiply: acc holds {partial product, remaining multiplier bits}; the
  // multiplicand is added into the top half when the multiplier LSB is set,
  // keeping the carry, then everything shifts right by one.
  // Divide: acc holds {partial remainder, dividend/quotient}; the next
  // dividend bit shifts into the remainder, the divisor is subtracted when
  // it fits and the quotient bit shifts in from the right.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    mul_next  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                         : {1'b0, acc_q[2*XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    div_next  = div_trial[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
  end

  // Next-state logic. The result register is loaded on the edge that enters
  // FINISH, from the next accumulator value, so it is already valid during
  // the cycle done is high. Fast-path results are stored pre-signed with
  // both sign flags cleared so the fix-up leaves them alone.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sign1_d     = sign1_q;
    sign2_d     = sign2_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    load_result = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d    = in_op;
          sign1_d = in_sign1;
          sign2_d = in_sign2;
          cnt_d   = '0;
          if (is_div_op(in_op)) begin
            if (bus.operand2 == '0) begin
              acc_d       = {bus.operand1, {XLEN{1'b1}}};
              sign1_d     = 1'b0;
              sign2_d     = 1'b0;
              state_d     = ST_FINISH;
              load_result = 1'b1;
            end else if (is_signed_rs1(in_op) && bus.operand1 == MOST_NEG &&
                         bus.operand2 == {XLEN{1'b1}}) begin
              acc_d       = {{XLEN{1'b0}}, MOST_NEG};
              sign1_d     = 1'b0;
              sign2_d     = 1'b0;
              state_d     = ST_FINISH;
              load_result = 1'b1;
            end else begin
              acc_d   = {{XLEN{1'b0}}, in_mag1};
              opnd_d  = in_mag2;
              state_d = ST_RUN;
            end
          end else begin
            acc_d   = {{XLEN{1'b0}}, in_mag2};
            opnd_d  = in_mag1;
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        acc_d = is_div_op(op_q) ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d     = ST_FINISH;
          load_result = 1'b1;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A kill returns to idle from anywhere and leaves the result untouched
    if (bus.flush) begin
      state_d     = ST_IDLE;
      load_result = 1'b0;
    end
  end

  mdu_sign_fix #(
    .XLEN(XLEN)
  ) u_sign_fix (
    .op    (op_d),
    .acc   (acc_d),
    .sign1 (sign1_d),
    .sign2 (sign2_d),
    .result(fixed_result)
  );

  // State and datapath registers; reset overrides flush and start
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= MDU_MUL;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sign1_q <= sign1_d;
      sign2_q <= sign2_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      if (load_result) begin
        result_q <= fixed_result;
        zero_q   <= (fixed_result == '0);
      end
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_FINISH);
  assign bus.result = result_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (XLEN = 32).
// A reference model predicts busy/done/result/zero from the instruction
// semantics and the fixed latencies; one compare process checks the DUT
// against it on every falling edge. A set of hand-computed operations pins
// both the model and the DUT to literal values.
module tb_mul_div_unit;

  logic clk;
  logic reset;

  mdu_if #(.XLEN(32)) bus ();

  mul_div_unit #(
    .XLEN(32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp;
  int n_bad;

  // Reference model state
  logic        m_busy;
  int          m_left;
  int          m_lat;
  logic [31:0] m_pend;
  logic [31:0] m_res;

  // Literal expectation handed from the stimulus to the compare process
  int          pin_seq;
  int          pin_done;
  string       pin_name;
  logic [31:0] pin_res;
  int          pin_lat;

  // Architectural result of an M-extension operation
  function automatic logic [31:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      sp;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin sp = sa * sb; return sp[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * longint'({32'h0, b}); return sp[63:32]; end
      3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sp = sa / sb;
        return sp[31:0];
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        sp = sa % sb;
        return sp[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Cycles from acceptance to the edge that samples done
  function automatic int ref_latency(input logic [2:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 32'h0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
  endfunction

  // Model: a completing operation always delivers its result, even if a
  // flush arrives in the done cycle; otherwise flush drops the operation
  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_left <= 0;
      m_res  <= 32'h0;
    end else if (m_busy && m_left == 1) begin
      m_busy <= 1'b0;
      m_res  <= m_pend;
    end else if (bus.flush) begin
      m_busy <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
    end else if (bus.start) begin
      m_busy <= 1'b1;
      m_left <= ref_latency(bus.op, bus.operand1, bus.operand2);
      m_lat  <= ref_latency(bus.op, bus.operand1, bus.operand2);
      m_pend <= ref_result(bus.op, bus.operand1, bus.operand2);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge
  always @(negedge clk) begin
    logic        exp_done;
    logic [31:0] exp_res;
    exp_done = m_busy && (m_left == 1);
    exp_res  = exp_done ? m_pend : m_res;
    checkOutput("busy", {31'h0, bus.busy}, {31'h0, m_busy});
    checkOutput("done", {31'h0, bus.done}, {31'h0, exp_done});
    if (!m_busy || exp_done) begin
      checkOutput("result", bus.result, exp_res);
      checkOutput("zero", {31'h0, bus.zero}, {31'h0, (exp_res == 32'h0)});
    end
    if (exp_done && pin_seq != pin_done) begin
      checkOutput({pin_name, " model result"}, m_pend, pin_res);
      checkOutput({pin_name, " model latency"}, m_lat, pin_lat);
      checkOutput({pin_name, " result"}, bus.result, pin_res);
      checkOutput({pin_name, " zero"}, {31'h0, bus.zero}, {31'h0, (pin_res == 32'h0)});
      pin_done = pin_seq;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one request for one edge, then scramble the inputs
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.operand1 = a;
    bus.operand2 = b;
    tick(1);
    bus.start    = 1'b0;
    bus.op       = 3'($urandom);
    bus.operand1 = $urandom;
    bus.operand2 = $urandom;
  endtask

  task automatic pin(input string name, input logic [31:0] res, input int lat);
    pin_name = name;
    pin_res  = res;
    pin_lat  = lat;
    pin_seq++;
  endtask

  task automatic waitModelDone();
    for (int k = 0; k < 100 && m_busy; k++) tick(1);
  endtask

  task automatic pinned(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat);
    pin(name, res, lat);
    applyStimulus(op, a, b);
    waitModelDone();
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    pin_seq      = 0;
    pin_done     = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.flush    = 1'b0;
    bus.op       = 3'd0;
    bus.operand1 = 32'h0;
    bus.operand2 = 32'h0;
    tick(2);
    reset = 1'b0;
    tick(1);

    // Hand-computed operations, issued back to back
    pinned("MUL 7*-3",        3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    pinned("MULHU -1*-1",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    pinned("MULH min*min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    pinned("MULHSU -1*max",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    pinned("DIV -7/2",        3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    pinned("REM -7%2",        3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    pinned("DIVU 100/7",      3'd5, 32'd100,       32'd7,         32'd14,        33);
    pinned("REMU 100%7",      3'd7, 32'd100,       32'd7,         32'd2,         33);
    pinned("DIVU 5/0",        3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    pinned("REM 5%0",         3'd6, 32'd5,         32'd0,         32'd5,         1);
    pinned("DIV min/-1",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    pinned("REM min%-1",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);

    // Second start while busy is ignored
    pin("MUL 3*4 with ignored start", 32'd12, 33);
    applyStimulus(3'd0, 32'd3, 32'd4);
    tick(9);
    applyStimulus(3'd0, 32'd5, 32'd5);
    waitModelDone();

    // Flush mid-operation: no done, result keeps 12
    applyStimulus(3'd5, 32'd1000, 32'd3);
    tick(14);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    tick(3);

    // Reset mid-divide
    applyStimulus(3'd4, 32'hFFFF_FC18, 32'd7);
    tick(19);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);

    // Randomised traffic including ignored starts, flushes and resets
    for (int i = 0; i < 4000; i++) begin
      bus.start    = ($urandom_range(0, 2) == 0);
      bus.op       = 3'($urandom);
      bus.operand1 = rnd_operand();
      bus.operand2 = rnd_operand();
      bus.flush    = ($urandom_range(0, 59) == 0);
      reset        = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    bus.start = 1'b0;
    bus.flush = 1'b0;
    reset     = 1'b0;
    tick(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
